// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake bundle for serial_add_ctrl: operand capture on
// start, result delivery on done, plus status flags.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             err;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout, err
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout, err
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Feeds an external combinational full adder
// one bit per clock from operand shift registers, keeps the running carry
// in carry_r and assembles a WIDTH-bit result, LSB first.
// Optional feature macro: SERIAL_ADD_SELFCHECK_EN -- builds a parallel
// reference adder and raises a sticky err flag when the serial result
// disagrees with it. Without the macro err is tied low.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus,
    output logic              fa_a,
    output logic              fa_b,
    output logic              fa_c,
    input  logic              fa_sum,
    input  logic              fa_carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Upper WIDTH-1 result bits collected so far; the newest bit joins at
    // the top through s_nxt, so the final word is s_nxt on the last edge.
    logic [WIDTH-2:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             run;
    logic             accept;
    logic             last;

    assign run    = (state == RUN);
    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last   = run && (cnt == LAST_CNT);
    assign s_nxt  = {fa_sum, s_sr};

    // Adder inputs come straight from registers and are quiet outside RUN.
    assign fa_a = run ? a_sr[0] : 1'b0;
    assign fa_b = run ? b_sr[0] : 1'b0;
    assign fa_c = run ? carry_r : 1'b0;

    assign bus.busy    = run;
    assign bus.done    = (state == DONE);
    assign bus.sum_out = sum_r;
    assign bus.cout    = cout_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE can accept a new start directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else if (accept) begin
            a_sr    <= bus.a_in;
            b_sr    <= bus.b_in;
            carry_r <= bus.cin;
            cnt     <= '0;
        end else if (run) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr    <= s_nxt[WIDTH-1:1];
            carry_r <= fa_carry;
            if (last) begin
                sum_r  <= s_nxt;
                cout_r <= fa_carry;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADD_SELFCHECK_EN
    logic [WIDTH-1:0] ref_a;
    logic [WIDTH-1:0] ref_b;
    logic             ref_c;
    logic [WIDTH:0]   ref_sum;
    logic             err_r;

    assign ref_sum = {1'b0, ref_a} + {1'b0, ref_b} + {{WIDTH{1'b0}}, ref_c};
    assign bus.err = err_r;

    // Operand copies and sticky compare against the parallel reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_a <= '0;
            ref_b <= '0;
            ref_c <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (accept) begin
                ref_a <= bus.a_in;
                ref_b <= bus.b_in;
                ref_c <= bus.cin;
            end
            if (last && ({fa_carry, s_nxt} != ref_sum)) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule
